// File: rtl/menu_ctrl.sv
// Game-selection controller: edge-detected buttons drive a MENU/SPEED/PLAY FSM with registered selects.
// Optional idle timeout back to MENU is built when MENU_IDLE_TIMEOUT_EN is defined.
module menu_ctrl #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int IDLE_SEC   = 30,
  parameter int N_GAMES    = 2,
  parameter int SPEED_INIT = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       button_up,
  input  logic       button_down,
  input  logic       button_left,
  input  logic       button_right,
  input  logic       exit,
  output logic [1:0] vgaMUX,
  output logic [1:0] choice,
  output logic [3:0] speedcontrol,
  output logic       game_active,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {MENU = 2'd0, SPEED = 2'd1, PLAY = 2'd2} state_t;

  localparam logic [1:0] LAST_GAME = 2'(N_GAMES - 1);
  localparam logic [3:0] SPEED_RST = 4'(SPEED_INIT);

  state_t     state, state_n;
  logic [1:0] cursor, cursor_n;
  logic [3:0] speed, speed_n;
  logic       acted;

  // Bit order {exit, left, right, up, down}. Both stages reset high so a
  // button held through reset is not seen as a press.
  logic [4:0] btn_s, btn_q, press;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      btn_s <= '1;
      btn_q <= '1;
    end else begin
      btn_s <= {exit, button_left, button_right, button_up, button_down};
      btn_q <= btn_s;
    end
  end

  assign press = btn_s & ~btn_q;

`ifdef MENU_IDLE_TIMEOUT_EN
  localparam int PW = $clog2(CLK_HZ);
  localparam int IW = $clog2(IDLE_SEC + 1);

  logic [PW-1:0] pre_cnt;
  logic [IW-1:0] idle_cnt, idle_cnt_n;
  logic          tick, timeout;

  assign tick    = (pre_cnt == PW'(CLK_HZ - 1));
  assign timeout = (idle_cnt >= IW'(IDLE_SEC));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      pre_cnt  <= tick ? '0 : pre_cnt + PW'(1);
      idle_cnt <= idle_cnt_n;
    end
  end
`endif

  always_comb begin
    state_n  = state;
    cursor_n = cursor;
    speed_n  = speed;
    acted    = 1'b0;
    unique case (state)
      MENU: begin
        // exit and left are not meaningful here, so they do not mask lower presses.
        if (press[2]) begin
          state_n = SPEED;
          acted   = 1'b1;
        end else if (press[1]) begin
          cursor_n = (cursor == 2'd0) ? LAST_GAME : cursor - 2'd1;
          acted    = 1'b1;
        end else if (press[0]) begin
          cursor_n = (cursor == LAST_GAME) ? 2'd0 : cursor + 2'd1;
          acted    = 1'b1;
        end
      end
      SPEED: begin
        if (press[4] || press[3]) begin
          state_n = MENU;
          acted   = 1'b1;
        end else if (press[2]) begin
          state_n = PLAY;
          acted   = 1'b1;
        end else if (press[1]) begin
          speed_n = (speed == 4'd15) ? speed : speed + 4'd1;
          acted   = 1'b1;
        end else if (press[0]) begin
          speed_n = (speed <= 4'd1) ? 4'd1 : speed - 4'd1;
          acted   = 1'b1;
        end
      end
      PLAY: begin
        if (press[4]) begin
          state_n = MENU;
          acted   = 1'b1;
        end
      end
      default: state_n = MENU;
    endcase

`ifdef MENU_IDLE_TIMEOUT_EN
    if (!acted && timeout && state != PLAY) begin
      state_n  = MENU;
      cursor_n = 2'd0;
    end
    idle_cnt_n = idle_cnt;
    if (acted || timeout || state == PLAY || state_n != state)
      idle_cnt_n = '0;
    else if (tick)
      idle_cnt_n = idle_cnt + IW'(1);
`endif
  end

  // Outputs are decoded from next-state values and registered alongside state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= MENU;
      cursor       <= 2'd0;
      speed        <= SPEED_RST;
      vgaMUX       <= 2'd0;
      choice       <= 2'd0;
      speedcontrol <= SPEED_RST;
      game_active  <= 1'b0;
    end else begin
      state        <= state_n;
      cursor       <= cursor_n;
      speed        <= speed_n;
      vgaMUX       <= (state_n == PLAY) ? cursor_n + 2'd1 : 2'd0;
      choice       <= (state_n == SPEED) ? 2'd3 : cursor_n;
      speedcontrol <= speed_n;
      game_active  <= (state_n == PLAY);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_menu_ctrl.sv
// Directed bench for menu_ctrl: drivers push hand-computed expected outputs, a negedge monitor pops and compares.
module tb_menu_ctrl;
`ifdef MENU_IDLE_TIMEOUT_EN
  localparam int CLK_HZ   = 10;
  localparam int IDLE_SEC = 3;
`else
  localparam int CLK_HZ   = 100_000_000;
  localparam int IDLE_SEC = 30;
`endif

  localparam logic [4:0] B_EXIT  = 5'b10000;
  localparam logic [4:0] B_LEFT  = 5'b01000;
  localparam logic [4:0] B_RIGHT = 5'b00100;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00001;

  logic       sys_clk, sys_rst_n;
  logic       button_up, button_down, button_left, button_right, exit;
  logic [1:0] vgaMUX, choice, state_dbg;
  logic [3:0] speedcontrol;
  logic       game_active;

  menu_ctrl #(.CLK_HZ(CLK_HZ), .IDLE_SEC(IDLE_SEC), .N_GAMES(2), .SPEED_INIT(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .button_up(button_up), .button_down(button_down),
    .button_left(button_left), .button_right(button_right), .exit(exit),
    .vgaMUX(vgaMUX), .choice(choice), .speedcontrol(speedcontrol),
    .game_active(game_active), .state_dbg(state_dbg)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // scoreboard: {vgaMUX, choice, speedcontrol, game_active}
  logic [8:0] exp_q[$];
  string      name_q[$];
  logic [8:0] cur_exp;
  int         total = 0;
  int         bad = 0;

  function automatic logic [8:0] pk(input int mux, input int ch, input int sp, input int act);
    logic [1:0] m;
    logic [1:0] c;
    logic [3:0] s;
    logic       a;
    m = 2'(mux);
    c = 2'(ch);
    s = 4'(sp);
    a = 1'(act);
    return {m, c, s, a};
  endfunction

  always @(negedge sys_clk) begin
    logic [8:0] e, a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {vgaMUX, choice, speedcontrol, game_active};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got mux=%0d ch=%0d spd=%0d act=%0d, want mux=%0d ch=%0d spd=%0d act=%0d",
                 n, a[8:7], a[6:5], a[4:1], a[0], e[8:7], e[6:5], e[4:1], e[0]);
      end
    end
  end

  // driver tasks
  task automatic set_btn(input logic [4:0] m);
    {exit, button_left, button_right, button_up, button_down} = m;
  endtask

  task automatic push(input logic [8:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    cur_exp = e;
  endtask

  // One-cycle pulse; outputs must hold for the sampling edge and change on the next.
  task automatic press(input logic [4:0] m, input string nm, input logic [8:0] e);
    @(negedge sys_clk); set_btn(m);
    @(posedge sys_clk); #1 push(cur_exp, {nm, "_pre"});
    @(negedge sys_clk); set_btn(5'b0);
    @(posedge sys_clk); #1 push(e, nm);
  endtask

  task automatic hold(input logic [4:0] m, input int cycles, input string nm, input logic [8:0] e);
    @(negedge sys_clk); set_btn(m);
    @(posedge sys_clk); #1 push(cur_exp, {nm, "_pre"});
    @(posedge sys_clk); #1 push(e, nm);
    repeat (cycles) @(posedge sys_clk);
    #1 push(e, {nm, "_held"});
    @(negedge sys_clk); set_btn(5'b0);
    repeat (2) @(posedge sys_clk);
    #1 push(e, {nm, "_released"});
  endtask

  task automatic idle(input int cycles, input string nm, input logic [8:0] e);
    repeat (cycles) @(posedge sys_clk);
    #1 push(e, nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_btn(5'b0);
    sys_rst_n = 1'b0;
    cur_exp = pk(0, 0, 4, 0);
    @(posedge sys_clk); #1 push(pk(0, 0, 4, 0), "reset");
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);

`ifdef MENU_IDLE_TIMEOUT_EN
    press(B_DOWN,  "to_cursor1", pk(0, 1, 4, 0));
    press(B_RIGHT, "to_speed",   pk(0, 3, 4, 0));
    for (int i = 0; i < 3; i++) idle(5, "speed_idle_short", pk(0, 3, 4, 0));
    press(B_UP, "restart_press", pk(0, 3, 5, 0));
    for (int i = 0; i < 3; i++) idle(5, "after_restart", pk(0, 3, 5, 0));
    idle(30, "timed_out", pk(0, 0, 5, 0));
    idle(5, "stay_menu", pk(0, 0, 5, 0));
`else
    press(B_DOWN, "down1", pk(0, 1, 4, 0));
    press(B_DOWN, "down2", pk(0, 0, 4, 0));
    press(B_DOWN, "down3", pk(0, 1, 4, 0));
    press(B_DOWN, "down4", pk(0, 0, 4, 0));
    press(B_UP,   "up_wrap", pk(0, 1, 4, 0));
    press(B_LEFT, "menu_left_ign", pk(0, 1, 4, 0));
    press(B_EXIT, "menu_exit_ign", pk(0, 1, 4, 0));
    press(B_RIGHT, "to_speed", pk(0, 3, 4, 0));
    for (int i = 0; i < 15; i++)
      press(B_UP, "speed_up", pk(0, 3, (4 + i + 1 > 15) ? 15 : 4 + i + 1, 0));
    for (int i = 0; i < 15; i++)
      press(B_DOWN, "speed_down", pk(0, 3, (15 - i - 1 < 1) ? 1 : 15 - i - 1, 0));
    for (int i = 0; i < 3; i++)
      press(B_UP, "speed_back", pk(0, 3, 2 + i, 0));
    press(B_LEFT | B_RIGHT | B_UP, "prio_left", pk(0, 1, 4, 0));
    press(B_RIGHT, "to_speed2", pk(0, 3, 4, 0));
    press(B_RIGHT, "to_play",   pk(2, 1, 4, 1));
    press(B_UP,    "play_up_ign",    pk(2, 1, 4, 1));
    press(B_DOWN,  "play_down_ign",  pk(2, 1, 4, 1));
    press(B_LEFT,  "play_left_ign",  pk(2, 1, 4, 1));
    press(B_RIGHT, "play_right_ign", pk(2, 1, 4, 1));
    press(B_EXIT,  "play_exit",      pk(0, 1, 4, 0));
    press(B_RIGHT, "to_speed3", pk(0, 3, 4, 0));
    press(B_EXIT | B_DOWN, "prio_exit", pk(0, 1, 4, 0));
    hold(B_DOWN, 100, "hold_down", pk(0, 0, 4, 0));
    press(B_DOWN,  "down5",    pk(0, 1, 4, 0));
    press(B_RIGHT, "to_speed4", pk(0, 3, 4, 0));
    press(B_RIGHT, "to_play2",  pk(2, 1, 4, 1));

    @(posedge sys_clk); #2;
    sys_rst_n = 1'b0;
    set_btn(B_RIGHT);
    #1;
    total++;
    if ({vgaMUX, choice, speedcontrol, game_active} !== pk(0, 0, 4, 0)) begin
      bad++;
      $display("FAIL rst_async: got mux=%0d ch=%0d spd=%0d act=%0d, want mux=0 ch=0 spd=4 act=0",
               vgaMUX, choice, speedcontrol, game_active);
    end
    push(pk(0, 0, 4, 0), "rst_mid_play");
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    idle(5, "right_held_thru_reset", pk(0, 0, 4, 0));
    @(negedge sys_clk); set_btn(5'b0);
    idle(2, "right_dropped", pk(0, 0, 4, 0));
    press(B_RIGHT, "right_repress", pk(0, 3, 4, 0));
    idle(1000, "no_timeout", pk(0, 3, 4, 0));
`endif

    repeat (3) @(posedge sys_clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    if (total < 12) begin
      bad++;
      $display("FAIL coverage: got %0d checks, want at least 12", total);
    end
    if (state_dbg > 2'd2) begin
      bad++;
      $display("FAIL state_dbg: got %0d, want 0..2", state_dbg);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else $display("FAIL: %0d mismatches", bad);
    $finish;
  end

endmodule
